// File: rtl/qdec_bin_arb_pkg.sv
// rtl/qdec_bin_arb_pkg.sv - shared arbiter state enum, requester indices and round-robin helper
package qdec_cabac_package;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } t_state_arb;

    localparam int REQ_SAO = 0;
    localparam int REQ_CU  = 1;
    localparam int REQ_DQP = 2;
    localparam int REQ_RES = 3;

    // Index of the k-th candidate after last, wrapping over n requesters.
    function automatic int rr_wrap(int last, int k, int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/qdec_bin_arb_if.sv
// rtl/qdec_bin_arb_if.sv - requester/engine bundle around the bin arbiter (QDEC_BIN_ARB_STATS_EN adds stats signals)
interface qdec_bin_arb_if #(
    parameter int NUM_REQ = 4
) (
    input logic clk
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*10-1:0] req_ctx_addr;
    logic [NUM_REQ-1:0]    req_ctx_addr_vld;
    logic [NUM_REQ-1:0]    req_dec_run;
    logic [NUM_REQ-1:0]    req_EPMode;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    req_dec_rdy;
    logic [NUM_REQ-1:0]    req_ruiBin;
    logic [NUM_REQ-1:0]    req_ruiBin_vld;
    logic [9:0]            ctx_addr;
    logic                  ctx_addr_vld;
    logic                  dec_run;
    logic                  EPMode;
    logic                  dec_rdy;
    logic                  ruiBin;
    logic                  ruiBin_vld;
    logic                  arb_err;
`ifdef QDEC_BIN_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] bin_cnt;
    logic                  stats_clr;
`endif

    // master: sub-FSMs plus decoding engine; slave: the arbiter itself
    modport master (
        input  clk,
`ifdef QDEC_BIN_ARB_STATS_EN
        output stats_clr,
        input  bin_cnt,
`endif
        output req, req_ctx_addr, req_ctx_addr_vld, req_dec_run, req_EPMode,
        output dec_rdy, ruiBin, ruiBin_vld,
        input  gnt, req_dec_rdy, req_ruiBin, req_ruiBin_vld,
        input  ctx_addr, ctx_addr_vld, dec_run, EPMode, arb_err
    );

    modport slave (
        input  clk,
`ifdef QDEC_BIN_ARB_STATS_EN
        input  stats_clr,
        output bin_cnt,
`endif
        input  req, req_ctx_addr, req_ctx_addr_vld, req_dec_run, req_EPMode,
        input  dec_rdy, ruiBin, ruiBin_vld,
        output gnt, req_dec_rdy, req_ruiBin, req_ruiBin_vld,
        output ctx_addr, ctx_addr_vld, dec_run, EPMode, arb_err
    );
endinterface

// File: rtl/qdec_bin_arb_rr_pick.sv
// rtl/qdec_bin_arb_rr_pick.sv - round-robin one-hot picker starting after last_gnt
module qdec_rr_pick
    import qdec_cabac_package::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'(rr_wrap(int'(last_gnt), k, N));
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/qdec_bin_arb.sv
// rtl/qdec_bin_arb.sv - CABAC bin-decoder arbiter between sub-FSMs and one decoding engine
// QDEC_BIN_ARB_STATS_EN adds per-requester delivered-bin counters (bin_cnt, stats_clr).
module qdec_bin_arb
    import qdec_cabac_package::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int OUTST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*10-1:0] req_ctx_addr,
    input  logic [NUM_REQ-1:0]    req_ctx_addr_vld,
    input  logic [NUM_REQ-1:0]    req_dec_run,
    input  logic [NUM_REQ-1:0]    req_EPMode,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    req_dec_rdy,
    output logic [NUM_REQ-1:0]    req_ruiBin,
    output logic [NUM_REQ-1:0]    req_ruiBin_vld,
    output logic [9:0]            ctx_addr,
    output logic                  ctx_addr_vld,
    output logic                  dec_run,
    output logic                  EPMode,
    input  logic                  dec_rdy,
    input  logic                  ruiBin,
    input  logic                  ruiBin_vld,
    output logic                  arb_err
`ifdef QDEC_BIN_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] bin_cnt,
    input  logic                  stats_clr
`endif
);

    localparam int         IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] OUT_MAX = 3'(OUTST_MAX);

    t_state_arb         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   own_idx, own_nxt;
    logic [IDX_W-1:0]   last_gnt, last_nxt;
    logic [2:0]         outst, outst_nxt;
    logic               own_run;
    logic               bin_ok;
    logic               err_now;
    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    qdec_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .win      (pick_win),
        .win_idx  (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            own_idx  <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
            outst    <= '0;
            arb_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            own_idx  <= own_nxt;
            last_gnt <= last_nxt;
            outst    <= outst_nxt;
            arb_err  <= arb_err | err_now;
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        own_nxt        = own_idx;
        last_nxt       = last_gnt;
        ctx_addr       = '0;
        ctx_addr_vld   = 1'b0;
        EPMode         = 1'b0;
        own_run        = 1'b0;
        req_dec_rdy    = '0;
        req_ruiBin     = '0;
        req_ruiBin_vld = '0;
        // A bin with nothing in flight is dropped rather than routed.
        bin_ok         = ruiBin_vld && (outst != 3'd0);

        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state != ARB_IDLE) && (own_idx == IDX_W'(i))) begin
                ctx_addr          = req_ctx_addr[i*10 +: 10];
                ctx_addr_vld      = req_ctx_addr_vld[i];
                EPMode            = req_EPMode[i];
                own_run           = req_dec_run[i];
                req_dec_rdy[i]    = dec_rdy;
                req_ruiBin[i]     = ruiBin;
                req_ruiBin_vld[i] = bin_ok;
            end
        end

        dec_run   = (state == ARB_GRANT) && own_run && (outst != OUT_MAX);
        outst_nxt = outst + 3'(dec_run) - 3'(bin_ok);

        // gnt is zero in ARB_IDLE, so any dec_run there counts as a non-owner request.
        err_now = (|(req_dec_run & ~gnt))
                || (ruiBin_vld && (outst == 3'd0))
                || (own_run && ((state == ARB_DRAIN) || (outst == OUT_MAX)));

        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_nxt   = pick_win;
                    own_nxt   = pick_idx;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!req[own_idx]) begin
                    if (outst_nxt == 3'd0) begin
                        state_nxt = ARB_IDLE;
                        gnt_nxt   = '0;
                        last_nxt  = own_idx;
                    end else begin
                        state_nxt = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                if (outst_nxt == 3'd0) begin
                    state_nxt = ARB_IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = own_idx;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

`ifdef QDEC_BIN_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst_n || stats_clr) begin
                cnt <= '0;
            end else if (req_ruiBin_vld[g] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign bin_cnt[g*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_qdec_bin_arb.sv
// tb/tb_qdec_bin_arb.sv - self-checking bench: vector table, directed corner cases, random vs model
module tb_qdec_bin_arb;
    import qdec_cabac_package::*;

    localparam int NR   = 4;
    localparam int OMAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qdec_bin_arb_if #(.NUM_REQ(NR)) bus (.clk(clk));

    qdec_bin_arb #(.NUM_REQ(NR), .OUTST_MAX(OMAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (bus.req),
        .req_ctx_addr     (bus.req_ctx_addr),
        .req_ctx_addr_vld (bus.req_ctx_addr_vld),
        .req_dec_run      (bus.req_dec_run),
        .req_EPMode       (bus.req_EPMode),
        .gnt              (bus.gnt),
        .req_dec_rdy      (bus.req_dec_rdy),
        .req_ruiBin       (bus.req_ruiBin),
        .req_ruiBin_vld   (bus.req_ruiBin_vld),
        .ctx_addr         (bus.ctx_addr),
        .ctx_addr_vld     (bus.ctx_addr_vld),
        .dec_run          (bus.dec_run),
        .EPMode           (bus.EPMode),
        .dec_rdy          (bus.dec_rdy),
        .ruiBin           (bus.ruiBin),
        .ruiBin_vld       (bus.ruiBin_vld),
        .arb_err          (bus.arb_err)
`ifdef QDEC_BIN_ARB_STATS_EN
        ,
        .bin_cnt          (bus.bin_cnt),
        .stats_clr        (bus.stats_clr)
`endif
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] run;
        logic       vld;
        logic [3:0] gnt;
        logic       eng_run;
        logic [3:0] own_vld;
        logic       err;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner index (-1 = none), drain flag, bins in flight.
    int m_owner;
    int m_last;
    int m_outst;
    bit m_drain;
    bit m_err;
    int m_cnt [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_outst = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    function automatic bit m_fwd();
        return (m_owner >= 0) && !m_drain && bus.req_dec_run[m_owner] && (m_outst < OMAX);
    endfunction

    // Compare against the model mid-cycle, then advance both across one edge.
    task automatic step();
        logic [NR-1:0] og;
        logic [9:0]    ectx;
        bit            ecv, eep, acc, fwd;
        og   = onehot(m_owner);
        acc  = bus.ruiBin_vld && (m_outst > 0);
        fwd  = m_fwd();
        ectx = '0;
        ecv  = 1'b0;
        eep  = 1'b0;
        if (m_owner >= 0) begin
            ectx = bus.req_ctx_addr[m_owner*10 +: 10];
            ecv  = bus.req_ctx_addr_vld[m_owner];
            eep  = bus.req_EPMode[m_owner];
        end
        chk("gnt", bus.gnt, og);
        chk("arb_err", bus.arb_err, m_err);
        chk("dec_run", bus.dec_run, fwd);
        chk("ctx_addr", bus.ctx_addr, ectx);
        chk("ctx_addr_vld", bus.ctx_addr_vld, ecv);
        chk("EPMode", bus.EPMode, eep);
        chk("req_dec_rdy", bus.req_dec_rdy, bus.dec_rdy ? og : '0);
        chk("req_ruiBin", bus.req_ruiBin, bus.ruiBin ? og : '0);
        chk("req_ruiBin_vld", bus.req_ruiBin_vld, acc ? og : '0);
`ifdef QDEC_BIN_ARB_STATS_EN
        for (int i = 0; i < NR; i++)
            chk($sformatf("bin_cnt%0d", i), bus.bin_cnt[i*16 +: 16], m_cnt[i]);
`endif
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if ((bus.req_dec_run & ~og) != '0) m_err = 1'b1;
            if (bus.ruiBin_vld && m_outst == 0) m_err = 1'b1;
            if (m_owner >= 0 && bus.req_dec_run[m_owner] && (m_drain || m_outst == OMAX)) m_err = 1'b1;
`ifdef QDEC_BIN_ARB_STATS_EN
            if (bus.stats_clr) begin
                for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            end else if (acc && m_owner >= 0 && m_cnt[m_owner] < 65535) begin
                m_cnt[m_owner]++;
            end
`endif
            m_outst = m_outst + int'(fwd) - int'(acc);
            if (m_owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (bus.req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
            end else if (!m_drain) begin
                if (!bus.req[m_owner]) begin
                    if (m_outst == 0) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end else begin
                        m_drain = 1'b1;
                    end
                end
            end else if (m_outst == 0) begin
                m_last  = m_owner;
                m_owner = -1;
                m_drain = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick();
        #2;
        step();
    endtask

    task automatic drv(input logic [3:0] r, input logic [3:0] run, input logic vld);
        bus.req         = r;
        bus.req_dec_run = run;
        bus.ruiBin_vld  = vld;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        logic [3:0] r;
        logic [3:0] run;
        logic       vld;

        tbl[0] = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[2] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[3] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0};
        tbl[4] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0};
        tbl[8] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};

        rst_n                = 1'b0;
        bus.req_ctx_addr     = {10'h3A3, 10'h2C2, 10'h1B1, 10'h0A0};
        bus.req_ctx_addr_vld = 4'b1011;
        bus.req_EPMode       = 4'b0101;
        bus.dec_rdy          = 1'b1;
        bus.ruiBin           = 1'b1;
`ifdef QDEC_BIN_ARB_STATS_EN
        bus.stats_clr        = 1'b0;
`endif
        drv(4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;

        #2;
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_err", bus.arb_err, 1'b0);
        chk("rst_dec_run", bus.dec_run, 1'b0);
        step();

        // Owner 2: grant, same-cycle run+bin at outst=2, then drain of 3 bins.
        for (int i = 0; i < 10; i++) begin
            drv(tbl[i].req, tbl[i].run, tbl[i].vld);
            #2;
            chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_dec_run", i), bus.dec_run, tbl[i].eng_run);
            chk($sformatf("tbl%0d_own_vld", i), bus.req_ruiBin_vld, tbl[i].own_vld);
            chk($sformatf("tbl%0d_err", i), bus.arb_err, tbl[i].err);
            if (i == 3) chk("same_cycle_outst", dut.outst, 3'd2);
            step();
        end

        // Round robin with all requesting: order 0,1,2,3,0, one idle cycle between owners.
        do_reset();
        drv(4'b1111, 4'b0000, 1'b0);
        tick();
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % NR;
            drv(4'b1111, onehot(e), 1'b0);
            #2;
            chk($sformatf("rr_gnt%0d", n), bus.gnt, onehot(e));
            step();
            drv(4'b1111, onehot(e), 1'b1);
            tick();
            drv(4'b1111 & ~onehot(e), 4'b0000, 1'b1);
            tick();
            drv(4'b1111, 4'b0000, 1'b0);
            #2;
            chk($sformatf("rr_idle%0d", n), bus.gnt, 4'b0000);
            step();
        end

        // Owner dec_run during drain is blocked and flagged.
        do_reset();
        drv(4'b0001, 4'b0000, 1'b0);
        tick();
        drv(4'b0001, 4'b0001, 1'b0);
        tick();
        drv(4'b0000, 4'b0000, 1'b0);
        tick();
        drv(4'b0000, 4'b0001, 1'b0);
        #2;
        chk("drain_block_run", bus.dec_run, 1'b0);
        chk("drain_gnt", bus.gnt, 4'b0001);
        step();
        drv(4'b0000, 4'b0000, 1'b0);
        #2;
        chk("drain_err", bus.arb_err, 1'b1);
        step();
        drv(4'b0000, 4'b0000, 1'b1);
        tick();
        drv(4'b0000, 4'b0000, 1'b0);
        #2;
        chk("drain_done_gnt", bus.gnt, 4'b0000);
        step();

        // Fifth dec_run at OUTST_MAX is suppressed.
        do_reset();
        drv(4'b0001, 4'b0000, 1'b0);
        tick();
        repeat (OMAX) begin
            drv(4'b0001, 4'b0001, 1'b0);
            tick();
        end
        drv(4'b0001, 4'b0001, 1'b0);
        #2;
        chk("max_block_run", bus.dec_run, 1'b0);
        chk("max_err_before", bus.arb_err, 1'b0);
        step();
        drv(4'b0001, 4'b0000, 1'b0);
        #2;
        chk("max_err_after", bus.arb_err, 1'b1);
        step();
        repeat (OMAX) begin
            drv(4'b0000, 4'b0000, 1'b1);
            tick();
        end

        // Non-owner dec_run while requester 0 owns the engine.
        do_reset();
        drv(4'b0001, 4'b0000, 1'b0);
        tick();
        drv(4'b0001, 4'b0010, 1'b0);
        #2;
        chk("nonown_dec_run", bus.dec_run, 1'b0);
        step();
        drv(4'b0001, 4'b0000, 1'b0);
        #2;
        chk("nonown_err", bus.arb_err, 1'b1);
        step();
        repeat (3) tick();
        #2;
        chk("nonown_err_sticky", bus.arb_err, 1'b1);
        step();
        do_reset();
        #2;
        chk("err_cleared", bus.arb_err, 1'b0);
        step();

`ifdef QDEC_BIN_ARB_STATS_EN
        drv(onehot(REQ_RES), 4'b0000, 1'b0);
        tick();
        repeat (5) begin
            drv(onehot(REQ_RES), onehot(REQ_RES), 1'b0);
            tick();
            drv(onehot(REQ_RES), 4'b0000, 1'b1);
            tick();
        end
        drv(onehot(REQ_RES), 4'b0000, 1'b0);
        #2;
        chk("bin_cnt_res_5", bus.bin_cnt[63:48], 16'd5);
        step();
        drv(onehot(REQ_RES), onehot(REQ_RES), 1'b0);
        tick();
        drv(onehot(REQ_RES), 4'b0000, 1'b1);
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        drv(4'b0000, 4'b0000, 1'b0);
        #2;
        chk("stats_clr_prio", bus.bin_cnt, '0);
        step();
        tick();
`endif

        // Random traffic, mostly protocol-clean, with rare errors and resets.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) r[$urandom_range(0, NR-1)] = ~r[$urandom_range(0, NR-1)];
            if ($urandom_range(0, 11) == 0) r = 4'($urandom);
            run = 4'b0000;
            if (m_owner >= 0 && !m_drain && $urandom_range(0, 1) == 1) run = onehot(m_owner);
            if ($urandom_range(0, 63) == 0) run[$urandom_range(0, NR-1)] = 1'b1;
            vld = (m_outst > 0) && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 63) == 0) vld = 1'b1;
            drv(r, run, vld);
            bus.req_ctx_addr     = 40'({$urandom(), $urandom()});
            bus.req_ctx_addr_vld = 4'($urandom);
            bus.req_EPMode       = 4'($urandom);
            bus.dec_rdy          = 1'($urandom);
            bus.ruiBin           = 1'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
